// File: rtl/servo_slew_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : servo_slew_scheduler
// Description : Per-channel target/current position store that slews each
//               channel toward its target by at most STEP counts per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_slew_scheduler #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 900_001,
    parameter int STEP      = 4,
    parameter int INIT_POS  = 128,
    localparam int CW       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clock_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [CW-1:0]         cmd_chan_i,
    input  logic [7:0]            cmd_pos_i,
    input  logic                  cmd_imm_i,
    output logic [CHANNELS*8-1:0] pos_o,
    output logic                  frame_o,
    output logic                  busy_o,
    output logic [CHANNELS-1:0]   settled_o,
    output logic                  err_o
);

    localparam int              CNTW     = $clog2(FRAME_LEN);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(CHANNELS - 1);
    localparam logic [CW:0]     CH_LIM   = (CW + 1)'(CHANNELS);
    localparam logic [8:0]      STEP9    = 9'(STEP);
    localparam logic [7:0]      STEP8    = 8'(STEP);
    localparam logic [7:0]      INIT8    = 8'(INIT_POS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic [CW-1:0]         index_q, index_d;
    logic [7:0]            cur_q [CHANNELS];
    logic [7:0]            cur_d [CHANNELS];
    logic [7:0]            tgt_q [CHANNELS];
    logic [7:0]            tgt_d [CHANNELS];
    logic [CHANNELS-1:0]   imm_q, imm_d;
    logic                  frame_q, frame_d;
    logic                  err_q, err_d;

    logic                  tick;
    logic                  accept;
    logic                  chan_ok;
    logic [7:0]            sel_cur;
    logic [7:0]            sel_tgt;
    logic                  sel_imm;
    logic signed [8:0]     diff;
    logic [8:0]            mag;
    logic                  snap;
    logic [7:0]            nxt_pos;

    always_comb begin
        tick    = (count_q == LAST_CNT);
        count_d = tick ? '0 : count_q + 1'b1;
        accept  = cmd_valid_i && (state_q == ST_IDLE);
        chan_ok = ({1'b0, cmd_chan_i} < CH_LIM);

        sel_cur = '0;
        sel_tgt = '0;
        sel_imm = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (index_q == CW'(i)) begin
                sel_cur = cur_q[i];
                sel_tgt = tgt_q[i];
                sel_imm = imm_q[i];
            end
        end

        // Both operands fit in 8 bits, so the 9-bit signed difference and its
        // magnitude cannot overflow; stepping toward the target never wraps.
        diff = $signed({1'b0, sel_tgt}) - $signed({1'b0, sel_cur});
        mag  = diff[8] ? 9'(-diff) : 9'(diff);
        snap = sel_imm || (mag <= STEP9);
        if (snap) begin
            nxt_pos = sel_tgt;
        end else if (!diff[8]) begin
            nxt_pos = sel_cur + STEP8;
        end else begin
            nxt_pos = sel_cur - STEP8;
        end

        state_d = state_q;
        index_d = index_q;
        frame_d = 1'b0;
        err_d   = err_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        imm_d   = imm_q;

        if (accept && !chan_ok) begin
            err_d = 1'b1;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            if (accept && chan_ok && (cmd_chan_i == CW'(i))) begin
                tgt_d[i] = cmd_pos_i;
                imm_d[i] = cmd_imm_i;
            end
            if ((state_q == ST_UPDATE) && (index_q == CW'(i))) begin
                cur_d[i] = nxt_pos;
                if (snap) begin
                    imm_d[i] = 1'b0;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_UPDATE;
                    index_d = '0;
                    frame_d = 1'b1;
                end
            end
            ST_UPDATE: begin
                if (index_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    index_d = '0;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            index_q <= '0;
            imm_q   <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cur_q[i] <= INIT8;
                tgt_q[i] <= INIT8;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            imm_q   <= imm_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cur_q[i] <= cur_d[i];
                tgt_q[i] <= tgt_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            assign pos_o[8*g +: 8] = cur_q[g];
            assign settled_o[g]    = (cur_q[g] == tgt_q[g]);
        end
    endgenerate

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_UPDATE);
    assign frame_o     = frame_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_slew_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_slew_scheduler
// Description : Directed-vector bench for servo_slew_scheduler (4- and
//               3-channel instances, FRAME_LEN=16, STEP=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_slew_scheduler;

    logic        clock_i = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_chan_i;
    logic [7:0]  cmd_pos_i;
    logic        cmd_imm_i;
    logic [31:0] pos_o;
    logic        frame_o;
    logic        busy_o;
    logic [3:0]  settled_o;
    logic        err_o;

    logic        cmd_valid3;
    logic        cmd_ready3;
    logic [1:0]  cmd_chan3;
    logic [7:0]  cmd_pos3;
    logic [23:0] pos3;
    logic        frame3;
    logic        busy3;
    logic [2:0]  settled3;
    logic        err3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock_i = ~clock_i;

    servo_slew_scheduler #(
        .CHANNELS (4),
        .FRAME_LEN(16),
        .STEP     (4),
        .INIT_POS (128)
    ) u_dut (
        .clock_i    (clock_i),
        .rst_n_i    (rst_n_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_chan_i (cmd_chan_i),
        .cmd_pos_i  (cmd_pos_i),
        .cmd_imm_i  (cmd_imm_i),
        .pos_o      (pos_o),
        .frame_o    (frame_o),
        .busy_o     (busy_o),
        .settled_o  (settled_o),
        .err_o      (err_o)
    );

    servo_slew_scheduler #(
        .CHANNELS (3),
        .FRAME_LEN(16),
        .STEP     (4),
        .INIT_POS (128)
    ) u_dut3 (
        .clock_i    (clock_i),
        .rst_n_i    (rst_n_i),
        .cmd_valid_i(cmd_valid3),
        .cmd_ready_o(cmd_ready3),
        .cmd_chan_i (cmd_chan3),
        .cmd_pos_i  (cmd_pos3),
        .cmd_imm_i  (1'b0),
        .pos_o      (pos3),
        .frame_o    (frame3),
        .busy_o     (busy3),
        .settled_o  (settled3),
        .err_o      (err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ch(input int c);
        return pos_o[8*c +: 8];
    endfunction

    // Called at a negedge; returns at the negedge where frame_o is high.
    task automatic wait_frame();
        int n = 0;
        while (!frame_o && n < 40) begin
            @(posedge clock_i);
            @(negedge clock_i);
            n++;
        end
        if (!frame_o) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pass();
        wait_frame();
        repeat (4) @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p, input logic imm);
        int n = 0;
        while (!cmd_ready_o && n < 20) begin
            @(posedge clock_i);
            @(negedge clock_i);
            n++;
        end
        if (!cmd_ready_o) chk("send_ready_timeout", 32'd0, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_chan_i  = c;
        cmd_pos_i   = p;
        cmd_imm_i   = imm;
        @(posedge clock_i);
        #1 cmd_valid_i = 1'b0;
        @(negedge clock_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int b;
        rst_n_i     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_chan_i  = '0;
        cmd_pos_i   = '0;
        cmd_imm_i   = 1'b0;
        cmd_valid3  = 1'b0;
        cmd_chan3   = '0;
        cmd_pos3    = '0;
        repeat (3) @(negedge clock_i);

        chk("rst_pos",     pos_o,       32'h8080_8080);
        chk("rst_settled", settled_o,   32'hf);
        chk("rst_ready",   cmd_ready_o, 32'd1);
        chk("rst_err",     err_o,       32'd0);
        chk("rst_busy",    busy_o,      32'd0);

        rst_n_i = 1'b1;
        n = 0;
        do begin
            @(posedge clock_i);
            @(negedge clock_i);
            n++;
        end while (!frame_o && n < 40);
        chk("first_frame_gap", n, 32'd16);

        n = 0;
        b = 0;
        do begin
            @(posedge clock_i);
            @(negedge clock_i);
            n++;
            if (busy_o) b++;
        end while (!frame_o && n < 40);
        chk("frame_period", n, 32'd16);
        chk("busy_cycles",  b, 32'd4);

        // Present a command exactly in the tick cycle (count 15).
        repeat (15) @(posedge clock_i);
        @(negedge clock_i);
        chk("tick_ready", cmd_ready_o, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_chan_i  = 2'd0;
        cmd_pos_i   = 8'd200;
        cmd_imm_i   = 1'b0;
        @(posedge clock_i);
        #1 cmd_valid_i = 1'b0;
        repeat (4) @(posedge clock_i);
        @(negedge clock_i);
        chk("tick_accept_ch0", ch(0), 32'd132);
        chk("tick_settled0",   settled_o[0], 32'd0);

        send(2'd0, 8'd128, 1'b1);
        send(2'd1, 8'd140, 1'b0);
        wait_pass();
        chk("imm_restore_ch0", ch(0), 32'd128);
        chk("slew1_ch1",       ch(1), 32'd132);
        chk("slew1_settled1",  settled_o[1], 32'd0);
        wait_pass();
        chk("slew2_ch1",       ch(1), 32'd136);
        chk("slew2_settled1",  settled_o[1], 32'd0);
        wait_pass();
        chk("slew3_ch1",       ch(1), 32'd140);
        chk("slew3_settled1",  settled_o[1], 32'd1);

        send(2'd2, 8'd0,   1'b1);
        send(2'd0, 8'd125, 1'b0);
        wait_pass();
        chk("imm_ch2",        ch(2), 32'd0);
        chk("small_step_ch0", ch(0), 32'd125);
        chk("all_settled",    settled_o, 32'hf);

        send(2'd3, 8'd255, 1'b0);
        repeat (31) wait_pass();
        chk("ch3_31_frames",   ch(3), 32'd252);
        chk("ch3_settled_31",  settled_o[3], 32'd0);
        wait_pass();
        chk("ch3_32_frames",   ch(3), 32'd255);
        chk("ch3_settled_32",  settled_o[3], 32'd1);

        // Command held valid from the frame_o cycle through the pass.
        wait_frame();
        cmd_valid_i = 1'b1;
        cmd_chan_i  = 2'd0;
        cmd_pos_i   = 8'd100;
        cmd_imm_i   = 1'b0;
        n = 0;
        while (!cmd_ready_o && n < 10) begin
            @(posedge clock_i);
            @(negedge clock_i);
            n++;
        end
        chk("ready_low_cycles", n, 32'd4);
        @(posedge clock_i);
        #1 cmd_valid_i = 1'b0;
        @(negedge clock_i);
        wait_pass();
        chk("held_cmd_ch0", ch(0), 32'd121);

        send(2'd1, 8'd150, 1'b0);
        send(2'd1, 8'd100, 1'b1);
        wait_pass();
        chk("last_write_ch1", ch(1), 32'd100);

        // Out-of-range channel on the 3-channel instance.
        n = 0;
        while (!cmd_ready3 && n < 20) begin
            @(posedge clock_i);
            @(negedge clock_i);
            n++;
        end
        chk("err3_before", err3, 32'd0);
        cmd_valid3 = 1'b1;
        cmd_chan3  = 2'd3;
        cmd_pos3   = 8'd7;
        @(posedge clock_i);
        #1 cmd_valid3 = 1'b0;
        @(negedge clock_i);
        chk("err3_set",   err3, 32'd1);
        chk("err3_pos",   pos3, 32'h80_8080);
        repeat (20) @(negedge clock_i);
        chk("err3_sticky",  err3, 32'd1);
        chk("err3_pos_late", pos3, 32'h80_8080);
        chk("err3_settled", settled3, 32'h7);

        // Asynchronous reset during UPDATE index 2.
        wait_frame();
        @(posedge clock_i);
        @(posedge clock_i);
        #2;
        rst_n_i     = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_chan_i  = 2'd1;
        cmd_pos_i   = 8'd10;
        cmd_imm_i   = 1'b1;
        #1;
        chk("midrst_pos",     pos_o,       32'h8080_8080);
        chk("midrst_busy",    busy_o,      32'd0);
        chk("midrst_ready",   cmd_ready_o, 32'd1);
        chk("midrst_settled", settled_o,   32'hf);
        chk("midrst_err3",    err3,        32'd0);
        repeat (2) @(negedge clock_i);
        rst_n_i     = 1'b1;
        cmd_valid_i = 1'b0;
        n = 0;
        do begin
            @(posedge clock_i);
            @(negedge clock_i);
            n++;
        end while (!frame_o && n < 40);
        chk("midrst_frame_gap", n, 32'd16);
        repeat (4) @(posedge clock_i);
        @(negedge clock_i);
        chk("midrst_cmd_ignored", pos_o, 32'h8080_8080);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
